// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch front end: FSM state codes, the IF/ID entry layout
// and the bubble value that decode treats as a no-op.
package fetch_stage_pkg;

   localparam logic [1:0]  ST_LOAD  = 2'b00;
   localparam logic [1:0]  ST_RUN   = 2'b01;
   localparam logic [1:0]  ST_HALT  = 2'b10;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_WORD, pc_plus4: 32'h0};

   // Branch targets are byte addresses; fetch only ever issues word-aligned addresses.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. Bubble wins over hold, hold wins over capture.
module ifid_reg
   import fetch_stage_pkg::*;
(
   input  logic  clk,
   input  logic  rst_ni,
   input  logic  hold_i,
   input  logic  bubble_i,
   input  ifid_t entry_i,
   output ifid_t entry_o
);

   ifid_t entry_q;
   ifid_t entry_d;

   always_comb begin
      entry_d = entry_q;
      if (bubble_i) begin
         entry_d = IFID_BUBBLE;
      end else if (!hold_i) begin
         entry_d = entry_i;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         entry_q <= IFID_BUBBLE;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: loads a program into instruction memory, then fetches
// one word per cycle into IF/ID until a HALT word is captured.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 256,
   parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        loadValid,
   output logic        loadReady,
   input  logic [31:0] loadWord,
   input  logic        loadLast,
   output logic [31:0] instrAddr,
   output logic [31:0] instrWriteData,
   output logic        instrWrite,
   output logic        instrRead,
   input  logic [31:0] instrData,
   input  logic        stall,
   input  logic        flush,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   output logic        ifidValid,
   output logic [31:0] ifidInstr,
   output logic [31:0] ifidPcPlus4,
   output logic        running,
   output logic        halted,
   output logic [15:0] cycleCount
);

   localparam int unsigned      IDX_W    = $clog2(IMEM_WORDS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMEM_WORDS - 1);

   logic [1:0]       state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [IDX_W-1:0] load_idx_q, load_idx_d;
   logic [15:0]      cycle_q, cycle_d;

   logic  ifid_hold;
   logic  ifid_bubble;
   ifid_t ifid_in;
   ifid_t ifid_out;
   logic  load_accept;
   logic  halt_seen;

   assign load_accept = (state_q == ST_LOAD) && loadValid;
   assign halt_seen   = (instrData == HALT_WORD);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      load_idx_d  = load_idx_q;
      cycle_d     = cycle_q;
      ifid_hold   = 1'b0;
      ifid_bubble = 1'b1;
      ifid_in     = '{valid: 1'b1, instr: instrData, pc_plus4: pc_q + 32'd4};
      case (state_q)
         ST_LOAD: begin
            if (load_accept) begin
               load_idx_d = load_idx_q + IDX_W'(1);
               if (loadLast || (load_idx_q == LAST_IDX)) begin
                  state_d = ST_RUN;
                  pc_d    = RESET_PC;
               end
            end
         end
         ST_RUN: begin
            cycle_d = cycle_q + 16'd1;
            if (branchTaken) begin
               pc_d = word_align(branchTarget);
            end else if (stall) begin
               ifid_hold   = 1'b1;
               ifid_bubble = flush;
            end else begin
               ifid_bubble = flush;
               // The PC stays parked on a captured HALT word so it remains visible afterwards.
               if (!flush && halt_seen) begin
                  state_d = ST_HALT;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= ST_LOAD;
         pc_q       <= RESET_PC;
         load_idx_q <= '0;
         cycle_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         load_idx_q <= load_idx_d;
         cycle_q    <= cycle_d;
      end
   end

   ifid_reg u_ifid (
      .clk      (clk),
      .rst_ni   (resetN),
      .hold_i   (ifid_hold),
      .bubble_i (ifid_bubble),
      .entry_i  (ifid_in),
      .entry_o  (ifid_out)
   );

   always_comb begin
      instrAddr      = pc_q;
      instrWriteData = 32'h0;
      instrWrite     = 1'b0;
      if (state_q == ST_LOAD) begin
         instrAddr      = 32'(load_idx_q) << 2;
         instrWriteData = loadWord;
         instrWrite     = load_accept;
      end
   end

   assign instrRead   = (state_q == ST_RUN);
   assign loadReady   = (state_q == ST_LOAD);
   assign running     = (state_q == ST_RUN);
   assign halted      = (state_q == ST_HALT);
   assign cycleCount  = cycle_q;
   assign ifidValid   = ifid_out.valid;
   assign ifidInstr   = ifid_out.instr;
   assign ifidPcPlus4 = ifid_out.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus randomized
// load/run sessions checked every cycle against a behavioural model.
module tb_fetch_stage;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam int N = 256;
   localparam int M_LOAD = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic clk = 1'b0;
   logic resetN = 1'b1;
   logic mem_init = 1'b1;
   always #5 clk = ~clk;

   logic        loadValid = 1'b0, loadLast = 1'b0;
   logic [31:0] loadWord = 32'h0;
   logic        stall = 1'b0, flush = 1'b0, branchTaken = 1'b0;
   logic [31:0] branchTarget = 32'h0;

   logic        loadReady, instrWrite, instrRead, ifidValid, running, halted;
   logic [31:0] instrAddr, instrWriteData, instrData, ifidInstr, ifidPcPlus4;
   logic [15:0] cycleCount;

   // Instruction memory seen by the DUT: combinational read, write on the clock edge.
   logic [31:0] env_mem [N];
   assign instrData = env_mem[instrAddr[9:2]];

   function automatic logic [31:0] fill(input int i);
      if (i == 4) return HALT;
      return 32'h1357_0000 + 32'(i) * 32'h11;
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < N; k++) env_mem[k] <= fill(k);
      end else if (instrWrite) begin
         env_mem[instrAddr[9:2]] <= instrWriteData;
      end
   end

   fetch_stage dut (
      .clk(clk), .resetN(resetN),
      .loadValid(loadValid), .loadReady(loadReady), .loadWord(loadWord), .loadLast(loadLast),
      .instrAddr(instrAddr), .instrWriteData(instrWriteData), .instrWrite(instrWrite),
      .instrRead(instrRead), .instrData(instrData),
      .stall(stall), .flush(flush), .branchTaken(branchTaken), .branchTarget(branchTarget),
      .ifidValid(ifidValid), .ifidInstr(ifidInstr), .ifidPcPlus4(ifidPcPlus4),
      .running(running), .halted(halted), .cycleCount(cycleCount)
   );

   // Small-capacity instance for the load-overflow boundary.
   logic        lv4 = 1'b0;
   logic [31:0] lw4 = 32'h0;
   logic        lr4, iw4, ir4, ifv4, run4, hlt4;
   logic [31:0] ia4, iwd4, ii4, ipc4;
   logic [15:0] cc4;

   fetch_stage #(.IMEM_WORDS(4)) dut4 (
      .clk(clk), .resetN(resetN),
      .loadValid(lv4), .loadReady(lr4), .loadWord(lw4), .loadLast(1'b0),
      .instrAddr(ia4), .instrWriteData(iwd4), .instrWrite(iw4),
      .instrRead(ir4), .instrData(32'h0),
      .stall(1'b0), .flush(1'b0), .branchTaken(1'b0), .branchTarget(32'h0),
      .ifidValid(ifv4), .ifidInstr(ii4), .ifidPcPlus4(ipc4),
      .running(run4), .halted(hlt4), .cycleCount(cc4)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model of the fetch front end.
   int          m_mode;
   int          m_idx;
   logic [31:0] m_pc;
   logic [15:0] m_cc;
   logic        m_v;
   logic [31:0] m_i, m_p4;
   logic [31:0] m_mem [N];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < N; k++) m_mem[k] <= fill(k);
      end else if (resetN && m_mode == M_LOAD && loadValid) begin
         m_mem[m_idx] <= loadWord;
      end
   end

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_mode <= M_LOAD; m_idx <= 0; m_pc <= 32'h0; m_cc <= 16'h0;
         m_v <= 1'b0; m_i <= 32'h0; m_p4 <= 32'h0;
      end else if (m_mode == M_LOAD) begin
         m_v <= 1'b0; m_i <= 32'h0; m_p4 <= 32'h0;
         if (loadValid) begin
            m_idx <= m_idx + 1;
            if (loadLast || m_idx == N - 1) begin
               m_mode <= M_RUN;
               m_pc   <= 32'h0;
            end
         end
      end else if (m_mode == M_RUN) begin
         m_cc <= m_cc + 16'd1;
         if (branchTaken) begin
            m_pc <= {branchTarget[31:2], 2'b00};
            m_v <= 1'b0; m_i <= 32'h0; m_p4 <= 32'h0;
         end else if (stall) begin
            if (flush) begin
               m_v <= 1'b0; m_i <= 32'h0; m_p4 <= 32'h0;
            end
         end else if (flush) begin
            m_v <= 1'b0; m_i <= 32'h0; m_p4 <= 32'h0;
            m_pc <= m_pc + 32'd4;
         end else begin
            m_v  <= 1'b1;
            m_i  <= m_mem[m_pc[9:2]];
            m_p4 <= m_pc + 32'd4;
            if (m_mem[m_pc[9:2]] == HALT) m_mode <= M_HALT;
            else m_pc <= m_pc + 32'd4;
         end
      end else begin
         m_v <= 1'b0; m_i <= 32'h0; m_p4 <= 32'h0;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("loadReady", loadReady, m_mode == M_LOAD);
      chk("running", running, m_mode == M_RUN);
      chk("halted", halted, m_mode == M_HALT);
      chk("instrRead", instrRead, m_mode == M_RUN);
      chk("instrWrite", instrWrite, m_mode == M_LOAD && loadValid);
      chk("instrAddr", instrAddr, (m_mode == M_LOAD) ? 32'(m_idx * 4) : m_pc);
      if (m_mode == M_LOAD) chk("instrWriteData", instrWriteData, loadWord);
      chk("ifidValid", ifidValid, m_v);
      chk("ifidInstr", ifidInstr, m_i);
      chk("ifidPcPlus4", ifidPcPlus4, m_p4);
      chk("cycleCount", 32'(cycleCount), 32'(m_cc));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      loadValid = 1'b0; loadLast = 1'b0; loadWord = 32'h0;
      stall = 1'b0; flush = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
   endtask

   initial begin
      int          cnt, len, guard;
      logic        acc;
      logic [31:0] w;

      #1 resetN = 1'b0;
      tick();
      tick();
      mem_init = 1'b0;
      chk("rst_loadReady", loadReady, 1);
      chk("rst_running", running, 0);
      chk("rst_halted", halted, 0);
      chk("rst_instrWrite", instrWrite, 0);
      chk("rst_instrRead", instrRead, 0);
      chk("rst_ifidValid", ifidValid, 0);
      chk("rst_cycleCount", 32'(cycleCount), 0);
      resetN = 1'b1;

      // Load a two-word program.
      loadValid = 1'b1; loadWord = 32'h2010_0002; #1;
      chk("t1_addr0", instrAddr, 32'h0);
      chk("t1_wr0", instrWrite, 1);
      tick();
      loadWord = 32'h2210_0003; loadLast = 1'b1; #1;
      chk("t1_addr4", instrAddr, 32'h4);
      chk("t1_wr4", instrWrite, 1);
      tick();
      loadValid = 1'b0; loadLast = 1'b0; #1;
      chk("t1_running", running, 1);
      chk("t1_loadReady", loadReady, 0);
      chk("t1_pc", instrAddr, 32'h0);
      chk("t1_mem0", instrData, 32'h2010_0002);

      // Two free-running fetches.
      tick();
      tick();
      chk("t2_instr", ifidInstr, 32'h2210_0003);
      chk("t2_pc4", ifidPcPlus4, 32'h8);
      chk("t2_valid", ifidValid, 1);
      chk("t2_pc", instrAddr, 32'h8);
      chk("t2_cc", 32'(cycleCount), 2);

      // Stall three cycles with a flush in the middle.
      stall = 1'b1;
      tick();
      chk("t3_hold_instr", ifidInstr, 32'h2210_0003);
      chk("t3_hold_pc", instrAddr, 32'h8);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t3_flush_valid", ifidValid, 0);
      chk("t3_flush_instr", ifidInstr, 32'h0);
      tick();
      stall = 1'b0;
      chk("t3_pc", instrAddr, 32'h8);
      chk("t3_cc", 32'(cycleCount), 5);

      // Branch overrides a simultaneous stall; target is word-aligned.
      branchTaken = 1'b1; branchTarget = 32'h13; stall = 1'b1;
      tick();
      branchTaken = 1'b0; stall = 1'b0; branchTarget = 32'h0;
      chk("t4_pc", instrAddr, 32'h10);
      chk("t4_valid", ifidValid, 0);
      chk("t4_halt_word", instrData, HALT);

      // HALT word at 0x10.
      tick();
      chk("t5_halted", halted, 1);
      chk("t5_instr", ifidInstr, HALT);
      chk("t5_valid", ifidValid, 1);
      chk("t5_cc", 32'(cycleCount), 7);
      loadValid = 1'b1; stall = 1'b1; branchTaken = 1'b1; branchTarget = 32'h40;
      repeat (3) tick();
      chk("t5_frozen_pc", instrAddr, 32'h10);
      chk("t5_frozen_cc", 32'(cycleCount), 7);
      chk("t5_bubble", ifidValid, 0);
      chk("t5_noload", instrWrite, 0);
      clear_inputs();
      resetN = 1'b0;
      #1;
      chk("t5_rst_halted", halted, 0);
      chk("t5_rst_loadReady", loadReady, 1);
      chk("t5_rst_cc", 32'(cycleCount), 0);
      chk("t5_rst_instr", ifidInstr, 32'h0);
      chk("t5_rst_read", instrRead, 0);
      tick();
      resetN = 1'b1;

      // Capacity boundary on the four-word instance.
      lv4 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         lw4 = 32'hA0 + 32'(k);
         #1;
         chk("t6_write", iw4, k < 4);
         if (k < 4) chk("t6_addr", ia4, 32'(k * 4));
         tick();
      end
      lv4 = 1'b0;
      chk("t6_running", run4, 1);
      chk("t6_loadReady", lr4, 0);

      // Randomized sessions.
      for (int it = 0; it < 8; it++) begin
         clear_inputs();
         resetN = 1'b0;
         tick();
         resetN = 1'b1;
         len = $urandom_range(2, 48);
         cnt = 0;
         guard = 0;
         while (m_mode == M_LOAD && guard < 500) begin
            loadValid = ($urandom_range(0, 3) != 0);
            w = $urandom;
            if (w == HALT) w = 32'h0;
            if (cnt == len - 1 && (it % 2) == 1) w = HALT;
            loadWord = w;
            loadLast = (cnt == len - 1);
            acc = loadValid;
            tick();
            if (acc) cnt++;
            guard++;
         end
         if (m_mode == M_LOAD) chk("load_timeout", 1, 0);
         clear_inputs();
         for (int c = 0; c < 400; c++) begin
            stall        = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 6) == 0);
            branchTaken  = ($urandom_range(0, 9) == 0);
            branchTarget = $urandom_range(0, len * 4 + 8);
            loadValid    = $urandom_range(0, 1);
            tick();
         end
      end

      clear_inputs();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
